// File: rtl/ram_file_arbiter.sv
// rtl/ram_file_arbiter.sv - CPU/debug arbiter in front of a single-port file-register RAM
module ram_file_arbiter #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 8,
  parameter int CLEAR_ON_RESET = 1,
  parameter int STARVE_LIMIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_ready,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  input  logic                  dbg_req,
  input  logic                  dbg_wr_en,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data_in,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_data_out,
  output logic                  clear_busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  // Wide enough to hold STARVE_LIMIT itself.
  localparam int SW = $clog2(STARVE_LIMIT + 2);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  dbg_out_q, dbg_out_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;

  logic dbg_free;
  logic forced;
  logic issue;
  logic cpu_sel;

  // A debug request may only be considered when nothing is awaiting its ack;
  // the ack cycle therefore ignores dbg_req, giving one issue per two cycles.
  assign dbg_free = (state_q == S_RUN) && dbg_req && !dbg_out_q;
  assign forced   = dbg_free && (starve_q == SW'(STARVE_LIMIT));
  assign issue    = dbg_free && (forced || !cpu_req);
  assign cpu_sel  = (state_q == S_RUN) && cpu_req && !forced;

  // State register: all flops, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      starve_q    <= '0;
      dbg_out_q   <= 1'b0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      starve_q    <= starve_d;
      dbg_out_q   <= dbg_out_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  // Next state: sweep the clear counter, then count cycles a debug request waits.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    starve_d    = starve_q;
    dbg_out_d   = issue;
    addr_hold_d = ram_addr;
    if (state_q == S_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) begin
        state_d = S_RUN;
      end
    end else if (issue) begin
      starve_d = '0;
    end else if (dbg_free) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Outputs: RAM port is a pure mux of the winning source; reset forces it quiet.
  always_comb begin
    ram_addr    = addr_hold_q;
    ram_wr_en   = 1'b0;
    ram_data_in = '0;
    cpu_ready   = 1'b0;
    clear_busy  = 1'b0;
    if (state_q == S_CLEAR) begin
      ram_addr   = clr_cnt_q;
      ram_wr_en  = 1'b1;
      clear_busy = 1'b1;
    end else begin
      cpu_ready = !forced;
      if (issue) begin
        ram_addr    = dbg_addr;
        ram_wr_en   = dbg_wr_en;
        ram_data_in = dbg_data_in;
      end else if (cpu_sel) begin
        ram_addr    = cpu_addr;
        ram_wr_en   = cpu_wr_en;
        ram_data_in = cpu_data_in;
      end
    end
    if (!rst_n) begin
      ram_addr    = '0;
      ram_wr_en   = 1'b0;
      ram_data_in = '0;
      cpu_ready   = 1'b0;
    end
  end

  assign dbg_ack      = dbg_out_q;
  assign dbg_data_out = dbg_out_q ? ram_data_out : '0;
  assign cpu_data_out = ram_data_out;

endmodule

// File: tb/tb_ram_file_arbiter.sv
// tb/tb_ram_file_arbiter.sv - self-checking bench for ram_file_arbiter
module tb_ram_file_arbiter;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int LIM = 15;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_req = 0, cpu_wr_en = 0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data_in = '0;
  logic          dbg_req = 0, dbg_wr_en = 0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data_in = '0;
  logic          cpu_ready, dbg_ack, clear_busy, ram_wr_en;
  logic [DW-1:0] cpu_data_out, dbg_data_out, ram_data_in, ram_data_out;
  logic [AW-1:0] ram_addr;

  ram_file_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1), .STARVE_LIMIT(LIM)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_ready(cpu_ready), .cpu_data_out(cpu_data_out),
    .dbg_req(dbg_req), .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_data_in(dbg_data_in),
    .dbg_ack(dbg_ack), .dbg_data_out(dbg_data_out), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Single-port RAM, registered read, old data returned on a same-cycle write.
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_addr] <= ram_data_in;
    ram_data_out <= ram[ram_addr];
  end

  // Second instance without power-on clear, idle inputs.
  logic          nc_zero1 = 1'b0;
  logic [AW-1:0] nc_zero_a = '0;
  logic [DW-1:0] nc_zero_d = '0;
  logic          nc_ready, nc_ack, nc_busy, nc_wr;
  logic [DW-1:0] nc_cdo, nc_ddo, nc_rdi;
  logic [AW-1:0] nc_addr;

  ram_file_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(0), .STARVE_LIMIT(LIM)) u_nc (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(nc_zero1), .cpu_wr_en(nc_zero1), .cpu_addr(nc_zero_a), .cpu_data_in(nc_zero_d),
    .cpu_ready(nc_ready), .cpu_data_out(nc_cdo),
    .dbg_req(nc_zero1), .dbg_wr_en(nc_zero1), .dbg_addr(nc_zero_a), .dbg_data_in(nc_zero_d),
    .dbg_ack(nc_ack), .dbg_data_out(nc_ddo), .clear_busy(nc_busy),
    .ram_addr(nc_addr), .ram_wr_en(nc_wr), .ram_data_in(nc_rdi), .ram_data_out(nc_zero_d)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: golden memory plus the arbitration rules in plain terms.
  logic [DW-1:0] gmem [0:DEPTH-1];
  bit            m_clear = 1;
  int            m_cnt = 0;
  bit            m_ack_due = 0, m_ack_rd = 0;
  logic [DW-1:0] m_ack_data;
  int            m_waited = 0;
  logic [AW-1:0] m_last = '0;
  bit            m_cpu_rd = 0;
  logic [DW-1:0] m_cpu_data;
  bit            e_issue, e_forced;

  logic          obs_ready, obs_ack, obs_wr;
  logic [DW-1:0] obs_cpu_dout, obs_dbg_dout;
  logic [AW-1:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check();
    bit free;
    obs_ready = cpu_ready; obs_ack = dbg_ack; obs_wr = ram_wr_en;
    obs_addr = ram_addr; obs_cpu_dout = cpu_data_out; obs_dbg_dout = dbg_data_out;
    e_issue = 0; e_forced = 0;
    if (!rst_n) begin
      chk("rst_wr", ram_wr_en, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_wdata", ram_data_in, 0);
      chk("rst_ready", cpu_ready, 0);
      chk("rst_busy", clear_busy, 1);
      chk("rst_ack", dbg_ack, 0);
    end else if (m_clear) begin
      chk("clr_wr", ram_wr_en, 1);
      chk("clr_addr", ram_addr, m_cnt);
      chk("clr_wdata", ram_data_in, 0);
      chk("clr_ready", cpu_ready, 0);
      chk("clr_busy", clear_busy, 1);
      chk("clr_ack", dbg_ack, 0);
    end else begin
      free = dbg_req && !m_ack_due;
      e_forced = free && (m_waited == LIM);
      e_issue = free && (e_forced || !cpu_req);
      chk("run_ready", cpu_ready, !e_forced);
      chk("run_busy", clear_busy, 0);
      if (e_issue) begin
        chk("dbg_addr", ram_addr, dbg_addr);
        chk("dbg_wr", ram_wr_en, dbg_wr_en);
        if (dbg_wr_en) chk("dbg_wdata", ram_data_in, dbg_data_in);
      end else if (cpu_req) begin
        chk("cpu_addr", ram_addr, cpu_addr);
        chk("cpu_wr", ram_wr_en, cpu_wr_en);
        if (cpu_wr_en) chk("cpu_wdata", ram_data_in, cpu_data_in);
      end else begin
        chk("idle_wr", ram_wr_en, 0);
        chk("idle_addr", ram_addr, m_last);
      end
      chk("ack", dbg_ack, m_ack_due);
      if (m_ack_due && m_ack_rd) chk("dbg_rdata", dbg_data_out, m_ack_data);
      if (m_cpu_rd) chk("cpu_rdata", cpu_data_out, m_cpu_data);
    end
    chk("nc_ready", nc_ready, rst_n);
    chk("nc_busy", nc_busy, 0);
  endtask

  task automatic update();
    bit cpu_acc;
    if (!rst_n) begin
      m_clear = 1; m_cnt = 0; m_ack_due = 0; m_waited = 0; m_last = '0; m_cpu_rd = 0;
    end else if (m_clear) begin
      gmem[m_cnt] = '0;
      m_last = AW'(m_cnt);
      m_cnt++;
      if (m_cnt == DEPTH) m_clear = 0;
    end else begin
      cpu_acc = cpu_req && !e_forced;
      if (e_issue) m_waited = 0;
      else if (dbg_req && !m_ack_due) m_waited++;
      m_ack_due = e_issue;
      m_ack_rd = e_issue && !dbg_wr_en;
      m_ack_data = gmem[dbg_addr];
      m_cpu_rd = cpu_acc && !cpu_wr_en;
      m_cpu_data = gmem[cpu_addr];
      if (e_issue && dbg_wr_en) gmem[dbg_addr] = dbg_data_in;
      else if (cpu_acc && cpu_wr_en) gmem[cpu_addr] = cpu_data_in;
      if (e_issue) m_last = dbg_addr;
      else if (cpu_acc) m_last = cpu_addr;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  initial begin
    // Reset, then full power-on clear.
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) tick();
    tick();
    chk("por_ready_512", obs_ready, 1);
    cpu_req = 1; cpu_wr_en = 0; cpu_addr = 9'h1FF;
    tick();
    cpu_req = 0;
    tick();
    chk("por_rd_1ff", obs_cpu_dout, 8'h00);

    // CPU write then read, no stall.
    cpu_req = 1; cpu_wr_en = 1; cpu_addr = 9'h020; cpu_data_in = 8'hA5;
    tick();
    chk("cpu_wr_nostall", obs_ready, 1);
    cpu_wr_en = 0;
    tick();
    chk("cpu_rd_nostall", obs_ready, 1);
    cpu_req = 0;
    tick();
    chk("cpu_rd_a5", obs_cpu_dout, 8'hA5);

    // Contention: debug read waits 15 cycles, forced slot on the 16th.
    cpu_req = 1; cpu_wr_en = 0; cpu_addr = 9'h005;
    dbg_req = 1; dbg_wr_en = 0; dbg_addr = 9'h020;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("cont_ready", obs_ready, (k != 16));
    end
    tick();
    chk("cont_ack", obs_ack, 1);
    chk("cont_data", obs_dbg_dout, 8'hA5);
    dbg_req = 0; cpu_req = 0;
    tick();

    // Idle CPU: debug write acks next cycle, read issued at N+2 returns it.
    dbg_req = 1; dbg_wr_en = 1; dbg_addr = 9'h070; dbg_data_in = 8'h3C;
    tick();
    chk("idle_wr_noack", obs_ack, 0);
    tick();
    chk("idle_wr_ack", obs_ack, 1);
    dbg_wr_en = 0;
    tick();
    chk("idle_rd_noack", obs_ack, 0);
    tick();
    chk("idle_rd_ack", obs_ack, 1);
    chk("idle_rd_3c", obs_dbg_dout, 8'h3C);
    dbg_req = 0;
    tick();

    // Random traffic against the model.
    for (int k = 0; k < 700; k++) begin
      bit stalled, acked;
      stalled = cpu_req && !obs_ready;
      acked = obs_ack;
      if (!stalled) begin
        cpu_req = ($urandom_range(0, 9) != 0);
        cpu_wr_en = $urandom_range(0, 1);
        cpu_addr = AW'($urandom_range(0, 15));
        cpu_data_in = DW'($urandom);
      end
      if (!dbg_req || acked) begin
        dbg_req = $urandom_range(0, 1);
        dbg_wr_en = $urandom_range(0, 1);
        dbg_addr = AW'($urandom_range(0, 15));
        dbg_data_in = DW'($urandom);
      end
      tick();
    end
    while (dbg_req) begin
      bit acked;
      acked = obs_ack;
      cpu_req = 0;
      if (acked) dbg_req = 0;
      else tick();
    end
    cpu_req = 0;
    tick();

    // Reset in the issue cycle of a debug read.
    dbg_req = 1; dbg_wr_en = 0; dbg_addr = 9'h020;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; dbg_req = 0;
    tick();
    chk("rst_mid_noack", obs_ack, 0);
    chk("rst_mid_addr0", obs_addr, 0);
    chk("rst_mid_wr", obs_wr, 1);
    for (int k = 1; k < DEPTH + 4; k++) tick();
    chk("rst_mid_ready", obs_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
